// File: rtl/lift_pkg.sv
// Shared types and floor-mask helpers for the N-floor lift controller.
package lift_pkg;

  localparam int MAXF = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } state_t;

  function automatic logic [MAXF-1:0] above_mask(input logic [31:0] idx);
    logic [MAXF-1:0] m;
    for (int i = 0; i < MAXF; i++) m[i] = (32'(i) > idx);
    return m;
  endfunction

  function automatic logic [MAXF-1:0] below_mask(input logic [31:0] idx);
    logic [MAXF-1:0] m;
    for (int i = 0; i < MAXF; i++) m[i] = (32'(i) < idx);
    return m;
  endfunction

endpackage

// File: rtl/lift_timer.sv
// Up-counter with synchronous clear and terminal-count flag.
module lift_timer #(
  parameter int CYCLES = 4,
  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tc
);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= count + 1'b1;
  end

  assign tc = (count == CW'(CYCLES - 1));

endmodule

// File: rtl/lift_ctrl_n.sv
// N-floor lift controller: latched requests served with a SCAN policy,
// timed floor-to-floor travel and door dwell.
module lift_ctrl_n
  import lift_pkg::*;
#(
  parameter int NUM_FLOORS    = 8,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 3,
  localparam int FW = $clog2(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_FLOORS-1:0] req,
  output logic [NUM_FLOORS-1:0] floor_onehot,
  output logic [FW-1:0]         floor_idx,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open,
  output logic                  arrive,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam logic [NUM_FLOORS-1:0] ONE = NUM_FLOORS'(1);

  state_t state;

  logic [NUM_FLOORS-1:0] eff;
  logic [NUM_FLOORS-1:0] clr;
  logic [NUM_FLOORS-1:0] cur_oh;
  logic [NUM_FLOORS-1:0] nf_oh;
  logic [FW-1:0]         nf;
  logic up_any, dn_any;
  logic cur_hit, nf_hit, nf_more, req_cur;
  logic mv, trv_clr, trv_tc;
  logic dr_en, dr_clr, dr_tc;

  always_comb begin
    eff     = pending | req;
    cur_oh  = ONE << floor_idx;
    nf      = (state == MOVE_DOWN) ? floor_idx - 1'b1
                                   : floor_idx + 1'b1;
    nf_oh   = ONE << nf;
    up_any  = |(32'(eff) & above_mask(32'(floor_idx)));
    dn_any  = |(32'(eff) & below_mask(32'(floor_idx)));
    cur_hit = |(eff & cur_oh);
    req_cur = |(req & cur_oh);
    nf_hit  = |(eff & nf_oh);
    nf_more = (state == MOVE_DOWN)
            ? |(32'(eff) & below_mask(32'(nf)))
            : |(32'(eff) & above_mask(32'(nf)));
    mv      = (state == MOVE_UP) || (state == MOVE_DOWN);
    trv_clr = !mv || trv_tc;
    dr_en   = (state == DOOR_OPEN);
    dr_clr  = !dr_en || req_cur || dr_tc;
    clr     = '0;
    unique case (state)
      IDLE:      if (cur_hit) clr = cur_oh;
      MOVE_UP,
      MOVE_DOWN: if (trv_tc && nf_hit) clr = nf_oh;
      DOOR_OPEN: clr = cur_oh;
      default:   clr = '0;
    endcase
  end

  lift_timer #(.CYCLES(TRAVEL_CYCLES)) u_travel (
    .clk   (clk),
    .rst_n (reset_n),
    .en    (mv),
    .clr   (trv_clr),
    .tc    (trv_tc)
  );

  lift_timer #(.CYCLES(DOOR_CYCLES)) u_door (
    .clk   (clk),
    .rst_n (reset_n),
    .en    (dr_en),
    .clr   (dr_clr),
    .tc    (dr_tc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      floor_idx    <= '0;
      floor_onehot <= ONE;
      dir_up       <= 1'b1;
      moving       <= 1'b0;
      door_open    <= 1'b0;
      arrive       <= 1'b0;
      pending      <= '0;
    end else begin
      pending <= (pending | req) & ~clr;
      arrive  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cur_hit) begin
            state     <= DOOR_OPEN;
            door_open <= 1'b1;
          end else if (up_any && (dir_up || !dn_any)) begin
            state  <= MOVE_UP;
            dir_up <= 1'b1;
            moving <= 1'b1;
          end else if (dn_any) begin
            state  <= MOVE_DOWN;
            dir_up <= 1'b0;
            moving <= 1'b1;
          end
        end
        MOVE_UP, MOVE_DOWN: begin
          if (trv_tc) begin
            floor_idx    <= nf;
            floor_onehot <= nf_oh;
            arrive       <= 1'b1;
            if (nf_hit) begin
              state     <= DOOR_OPEN;
              moving    <= 1'b0;
              door_open <= 1'b1;
            end else if (!nf_more) begin
              state  <= IDLE;
              moving <= 1'b0;
            end
          end
        end
        DOOR_OPEN: begin
          // a request at this floor keeps the door open
          if (dr_tc && !req_cur) begin
            state     <= IDLE;
            door_open <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lift_ctrl_n.sv
// Directed bench for lift_ctrl_n with default parameters
// (8 floors, 4 travel cycles, 3 door cycles).
module tb_lift_ctrl_n;

  logic       clk;
  logic       reset_n;
  logic [7:0] req;
  logic [7:0] floor_onehot;
  logic [2:0] floor_idx;
  logic       dir_up;
  logic       moving;
  logic       door_open;
  logic       arrive;
  logic [7:0] pending;

  int tests = 0;
  int fails = 0;

  lift_ctrl_n dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req          (req),
    .floor_onehot (floor_onehot),
    .floor_idx    (floor_idx),
    .dir_up       (dir_up),
    .moving       (moving),
    .door_open    (door_open),
    .arrive       (arrive),
    .pending      (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_floor(input string tag, input int f);
    logic [7:0] oh;
    oh = 8'h01 << f;
    chk({tag, ".idx"}, 32'(floor_idx), 32'(f));
    chk({tag, ".oh"}, 32'(floor_onehot), 32'(oh));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req = '0;
    #3;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    req = '0;
    #12;
    reset_n = 1'b1;

    // reset state
    chk_floor("rst", 0);
    chk("rst.dir", 32'(dir_up), 1);
    chk("rst.mov", 32'(moving), 0);
    chk("rst.door", 32'(door_open), 0);
    chk("rst.arr", 32'(arrive), 0);
    chk("rst.pend", 32'(pending), 0);

    // request at the current floor
    req = 8'h01;
    tick(1);
    req = '0;
    chk("t1.door0", 32'(door_open), 1);
    chk("t1.pend", 32'(pending), 0);
    tick(2);
    chk("t1.door2", 32'(door_open), 1);
    tick(1);
    chk("t1.door3", 32'(door_open), 0);
    chk("t1.mov", 32'(moving), 0);

    // 0 -> 3
    do_reset();
    req = 8'h08;
    tick(1);
    req = '0;
    chk("t2.mov", 32'(moving), 1);
    chk("t2.pend", 32'(pending), 8'h08);
    tick(3);
    chk_floor("t2.e3", 0);
    chk("t2.arr3", 32'(arrive), 0);
    tick(1);
    chk_floor("t2.e4", 1);
    chk("t2.arr4", 32'(arrive), 1);
    tick(1);
    chk("t2.arr5", 32'(arrive), 0);
    tick(3);
    chk_floor("t2.e8", 2);
    chk("t2.arr8", 32'(arrive), 1);
    tick(4);
    chk_floor("t2.e12", 3);
    chk("t2.door12", 32'(door_open), 1);
    chk("t2.mov12", 32'(moving), 0);
    chk("t2.pend12", 32'(pending), 0);
    tick(2);
    chk("t2.door14", 32'(door_open), 1);
    tick(1);
    chk("t2.door15", 32'(door_open), 0);

    // up to 7 first, then reverse to 2
    do_reset();
    req = 8'h80;
    tick(1);
    req = '0;
    tick(20);
    chk_floor("t3.e20", 5);
    chk("t3.dir20", 32'(dir_up), 1);
    req = 8'h04;
    tick(1);
    req = '0;
    chk("t3.pend21", 32'(pending), 8'h84);
    tick(7);
    chk_floor("t3.e28", 7);
    chk("t3.door28", 32'(door_open), 1);
    chk("t3.pend28", 32'(pending), 8'h04);
    tick(3);
    chk("t3.door31", 32'(door_open), 0);
    chk("t3.mov31", 32'(moving), 0);
    tick(1);
    chk("t3.mov32", 32'(moving), 1);
    chk("t3.dir32", 32'(dir_up), 0);
    tick(4);
    chk_floor("t3.e36", 6);
    chk("t3.arr36", 32'(arrive), 1);
    tick(8);
    chk_floor("t3.e44", 4);
    tick(8);
    chk_floor("t3.e52", 2);
    chk("t3.door52", 32'(door_open), 1);
    chk("t3.pend52", 32'(pending), 0);
    chk("t3.dir52", 32'(dir_up), 0);

    // pass-through stop at 4 on the way to 6
    do_reset();
    req = 8'h40;
    tick(1);
    req = '0;
    tick(8);
    chk_floor("t4.e8", 2);
    req = 8'h10;
    tick(1);
    req = '0;
    chk("t4.pend9", 32'(pending), 8'h50);
    tick(3);
    chk_floor("t4.e12", 3);
    chk("t4.door12", 32'(door_open), 0);
    chk("t4.mov12", 32'(moving), 1);
    tick(4);
    chk_floor("t4.e16", 4);
    chk("t4.door16", 32'(door_open), 1);
    chk("t4.pend16", 32'(pending), 8'h40);
    tick(3);
    chk("t4.door19", 32'(door_open), 0);
    tick(1);
    chk("t4.mov20", 32'(moving), 1);
    chk("t4.dir20", 32'(dir_up), 1);
    tick(8);
    chk_floor("t4.e28", 6);
    chk("t4.door28", 32'(door_open), 1);
    chk("t4.pend28", 32'(pending), 0);

    // door dwell extension: req[0] held over four edges
    do_reset();
    req = 8'h01;
    tick(1);
    chk("t5.door0", 32'(door_open), 1);
    for (int i = 1; i <= 3; i++) begin
      tick(1);
      chk("t5.doorh", 32'(door_open), 1);
      chk("t5.pendh", 32'(pending), 0);
    end
    req = '0;
    tick(2);
    chk("t5.door5", 32'(door_open), 1);
    tick(1);
    chk("t5.door6", 32'(door_open), 0);
    chk("t5.pend6", 32'(pending), 0);

    // reset between floors 2 and 3
    do_reset();
    req = 8'h08;
    tick(1);
    req = '0;
    tick(9);
    chk_floor("t6.e10", 2);
    chk("t6.pend10", 32'(pending), 8'h08);
    reset_n = 1'b0;
    #1;
    chk_floor("t6.rst", 0);
    chk("t6.mov", 32'(moving), 0);
    chk("t6.pend", 32'(pending), 0);
    chk("t6.arr", 32'(arrive), 0);
    chk("t6.dir", 32'(dir_up), 1);
    chk("t6.door", 32'(door_open), 0);
    #2;
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk("t6.arrq", 32'(arrive), 0);
      chk_floor("t6.q", 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lift_ctrl_n.md
Name: lift_ctrl_n

Overview:
- Parametrised N-floor lift controller; successor to the 3-floor one-hot lift FSM.
- Latches floor requests into a pending mask and serves them with a SCAN (keep-direction) policy.
- Models per-floor travel time and a timed door-open dwell.
- Drives one-hot and binary floor indication plus status outputs to the display/annunciator logic.

Parameters:
NUM_FLOORS, 8, number of floors (>=2); floor 0 = ground.
TRAVEL_CYCLES, 4, clock cycles to move one floor (>=1).
DOOR_CYCLES, 3, cycles door stays open per stop (>=1).
FW, $clog2(NUM_FLOORS), derived floor-index width (localparam, not overridable).

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
req  in  NUM_FLOORS  request bitmask (cab/hall merged); level or 1-cycle pulse, sampled every edge.
floor_onehot  out  NUM_FLOORS  current floor, one-hot (bit k = floor k).
floor_idx  out  FW  current floor, binary.
dir_up  out  1  current/last travel direction (1 = up).
moving  out  1  high in MOVE_UP/MOVE_DOWN.
door_open  out  1  high in DOOR_OPEN.
arrive  out  1  1-cycle pulse in the cycle after floor_idx changes.
pending  out  NUM_FLOORS  latched unserved requests.

Behaviour:
- Interface: one clock `clk`; reset `reset_n` is asynchronous and active-low.
- Reset (async assert, sync-released use):
  - state = IDLE, floor_idx = 0, floor_onehot = 1, dir_up = 1.
  - pending = 0, moving = 0, door_open = 0, arrive = 0.
  - Travel and door counters = 0.
  - Reset mid-travel or mid-door returns to floor 0 immediately; pending is lost.
- Request latch, every edge: pending <= (pending | req) & ~clr.
  - clr = onehot(floor_idx) on entry to DOOR_OPEN.
  - In DOOR_OPEN, clr also covers req at the current floor; it is never latched.
- States:
  - IDLE: uses eff = pending | req (combinational).
    - eff == 0 -> stay.
    - eff[floor_idx] -> DOOR_OPEN.
    - Else if any eff above and (dir_up, or none below) -> MOVE_UP, dir_up = 1.
    - Else -> MOVE_DOWN, dir_up = 0.
    - Latency: req at the current floor sampled at edge E -> door_open high after E.
  - MOVE_UP / MOVE_DOWN: travel counter increments each cycle.
    - At count == TRAVEL_CYCLES-1: floor_idx +/- 1, counter <= 0, arrive pulses next cycle.
    - On that same edge, if (pending|req) at the new floor -> DOOR_OPEN.
    - Else if requests remain further in the current direction -> stay and continue.
    - Else -> IDLE.
  - DOOR_OPEN: door counter runs; at count == DOOR_CYCLES-1 -> IDLE.
    - req at the current floor during DOOR_OPEN reloads the door counter to 0 (dwell extension).
- Bounds:
  - Never increments past NUM_FLOORS-1 or decrements below 0; the direction test excludes those.
  - Simultaneous requests above and below in IDLE: continue dir_up.
  - Requests arriving during travel are latched and served when the car passes or turns.
- Outputs are registered, except pending, which is the register itself.
- floor_onehot is always exactly one-hot and consistent with floor_idx.

Decomposition:
- Package lift_pkg holds:
  - state enum (IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN), 2 bits.
  - Helper functions above_mask(idx) and below_mask(idx).
- One sub-module, lift_timer: loadable up-counter with terminal-count flag and clear.
  - Instantiated twice, for travel (TRAVEL_CYCLES) and door (DOOR_CYCLES).

Test Plan:
- Reset at floor 0, req = 8'b0000_0001 pulse at E0 -> door_open high after E0 for 3 cycles; pending stays 0; then IDLE.
- req[3] pulse at E0 from floor 0 (defaults):
  - floor_idx 1/2/3 at E4/E8/E12, arrive pulse after each.
  - door_open after E12 for 3 cycles; pending[3] cleared at E12.
- Car at 5 moving up with req[7] pending; req[2] pulsed:
  - Services 7 first, then dir_up = 0, travels down, stops at 2.
  - floor_onehot correct throughout.
- Pass-through stop: moving 0->6, req[4] pulsed while floor_idx = 2 -> stops at 4, door cycle, then resumes to 6.
- Door extension: req at current floor held 4 cycles during DOOR_OPEN -> door_open lasts 4+2 cycles; pending bit never set.
- reset_n asserted mid-travel, between floors 2 and 3 -> outputs immediately at reset values; pending = 0; no arrive pulse.
